// File: rtl/lc3_ctrl_pkg.sv
// lc3_ctrl_pkg: opcodes, memory-access states and opcode classifiers shared by the pipeline controller.
package lc3_ctrl_pkg;
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;

    typedef enum logic [1:0] {
        MEM_READ  = 2'd0,
        MEM_IND   = 2'd1,
        MEM_WRITE = 2'd2,
        MEM_IDLE  = 2'd3
    } mem_state_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op == OP_ADD || op == OP_AND || op == OP_NOT;
    endfunction

    function automatic logic is_load_op(input logic [3:0] op);
        return op == OP_LD || op == OP_LDR || op == OP_LDI;
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        return op == OP_ST || op == OP_STR || op == OP_STI;
    endfunction
endpackage

// File: rtl/lc3_pipe_controller_if.sv
// lc3_pipe_controller_if: controller/datapath bundle; master is the controller side, slave the datapath side.
interface lc3_pipe_controller_if;
    import lc3_ctrl_pkg::*;
    logic        complete_instr;
    logic        complete_data;
    logic [15:0] IR;
    logic [15:0] IR_Exec;
    logic [2:0]  NZP;
    logic [2:0]  psr;
    logic        enable_updatePC;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        br_taken;
    mem_state_e  mem_state;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic        bypass_mem_1;
    logic        bypass_mem_2;
    logic        mem_err;

    modport master (
        input  complete_instr, complete_data, IR, IR_Exec, NZP, psr,
        output enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
        output br_taken, mem_state, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, mem_err
    );

    modport slave (
        output complete_instr, complete_data, IR, IR_Exec, NZP, psr,
        input  enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
        input  br_taken, mem_state, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, mem_err
    );
endinterface

// File: rtl/lc3_pipe_controller_bypass_unit.sv
// lc3_bypass_unit: combinational operand forwarding from the execute/writeback register to decode/execute.
module lc3_bypass_unit
    import lc3_ctrl_pkg::*;
(
    input  logic [3:0] ir_op,
    input  logic [2:0] ir_sr1,
    input  logic [2:0] ir_sr2,
    input  logic       ir_imm,
    input  logic [3:0] ex_op,
    input  logic [2:0] ex_dr,
    output logic       alu_1,
    output logic       alu_2,
    output logic       mem_1,
    output logic       mem_2
);
    logic src1, src2;
    always_comb begin
        src1  = ir_op == OP_ADD || ir_op == OP_AND || ir_op == OP_NOT ||
                ir_op == OP_LDR || ir_op == OP_STR || ir_op == OP_JMP;
        src2  = (ir_op == OP_ADD || ir_op == OP_AND) && !ir_imm;
        alu_1 = is_alu_op(ex_op) && src1 && ex_dr == ir_sr1;
        alu_2 = is_alu_op(ex_op) && src2 && ex_dr == ir_sr2;
        mem_1 = is_load_op(ex_op) && src1 && ex_dr == ir_sr1;
        mem_2 = is_load_op(ex_op) && src2 && ex_dr == ir_sr2;
    end
endmodule

// File: rtl/lc3_pipe_controller.sv
// lc3_pipe_controller: stage enables, memory-access FSM, branch bubbles and bypass selects.
// Defining LC3_CTRL_TIMEOUT_EN adds a memory-wait timeout with a sticky mem_err flag.
module lc3_pipe_controller
    import lc3_ctrl_pkg::*;
#(
    parameter int BR_BUBBLES  = 3,
    parameter int MEM_TIMEOUT = 255
) (
    input logic clock,
    input logic reset,
    lc3_pipe_controller_if.master bus
);
    localparam int BW = $clog2(BR_BUBBLES + 1);

    logic [3:0]    ir_op, ex_op;
    logic [2:0]    fill_q, fill_d;
    mem_state_e    mem_q, mem_d;
    logic          mem_wr_q, mem_wr_d, mem_done_q, mem_done_d;
    logic [BW-1:0] bub_q, bub_d;
    logic          br_jmp_q, br_jmp_d, br_done_q, br_done_d;
    logic          en_upc_q, en_upc_d, en_fetch_q, en_fetch_d, en_dec_q, en_dec_d;
    logic          en_exe_q, en_exe_d, en_wb_q, en_wb_d, br_taken_q, br_taken_d;
    logic          mem_trig, br_trig, mem_ok, bub_ok;
    logic          alu_1, alu_2, mem_1, mem_2;
    logic          unused;

    assign ir_op = bus.IR[15:12];
    assign ex_op = bus.IR_Exec[15:12];

`ifdef LC3_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    logic [TW-1:0] tout_q, tout_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        fill_d   = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
        mem_trig = en_exe_q && !mem_done_q && (is_load_op(ex_op) || is_store_op(ex_op));
        mem_d    = mem_q;
        mem_wr_d = mem_wr_q;
        if (mem_q == MEM_IDLE) begin
            if (mem_trig) begin
                mem_wr_d = is_store_op(ex_op);
                mem_d    = (ex_op == OP_LDI || ex_op == OP_STI) ? MEM_IND :
                           is_store_op(ex_op) ? MEM_WRITE : MEM_READ;
            end
        end else if (bus.complete_data) begin
            mem_d = (mem_q != MEM_IND) ? MEM_IDLE : mem_wr_q ? MEM_WRITE : MEM_READ;
        end
`ifdef LC3_CTRL_TIMEOUT_EN
        err_d = err_q;
        if (mem_q != MEM_IDLE && !bus.complete_data && tout_q == TW'(MEM_TIMEOUT - 1)) begin
            mem_d = MEM_IDLE;
            err_d = 1'b1;
        end
        tout_d = (mem_q != MEM_IDLE && mem_d == mem_q) ? tout_q + 1'b1 : '0;
`endif
        // done flags stop a held instruction from re-triggering until its stage advances
        mem_done_d = (mem_q != MEM_IDLE && mem_d == MEM_IDLE) ? 1'b1 : en_exe_q ? 1'b0 : mem_done_q;
        mem_ok     = mem_q == MEM_IDLE && mem_d == MEM_IDLE;
        br_trig    = en_dec_q && !br_done_q && (ir_op == OP_BR || ir_op == OP_JMP);
        bub_d      = (mem_q != MEM_IDLE) ? bub_q : br_trig ? BW'(BR_BUBBLES) :
                     (bub_q != '0) ? bub_q - 1'b1 : bub_q;
        br_jmp_d   = (br_trig && mem_q == MEM_IDLE) ? ir_op == OP_JMP : br_jmp_q;
        br_done_d  = (bub_q != '0 && bub_d == '0) ? 1'b1 : en_dec_q ? 1'b0 : br_done_q;
        bub_ok     = bub_d == '0;
        br_taken_d = bub_d == BW'(1) && bub_q != BW'(1) && (br_jmp_d || |(bus.NZP & bus.psr));
        en_upc_d   = bus.complete_instr && mem_ok && bub_ok;
        en_fetch_d = bus.complete_instr && mem_ok && bub_ok;
        en_dec_d   = fill_d >= 3'd2 && mem_ok && bub_ok;
        en_exe_d   = fill_d >= 3'd3 && mem_ok;
        en_wb_d    = fill_d >= 3'd4 && (mem_ok || mem_d == MEM_READ);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fill_q     <= '0;
            mem_q      <= MEM_IDLE;
            mem_wr_q   <= 1'b0;
            mem_done_q <= 1'b0;
            bub_q      <= '0;
            br_jmp_q   <= 1'b0;
            br_done_q  <= 1'b0;
            en_upc_q   <= 1'b0;
            en_fetch_q <= 1'b0;
            en_dec_q   <= 1'b0;
            en_exe_q   <= 1'b0;
            en_wb_q    <= 1'b0;
            br_taken_q <= 1'b0;
        end else begin
            fill_q     <= fill_d;
            mem_q      <= mem_d;
            mem_wr_q   <= mem_wr_d;
            mem_done_q <= mem_done_d;
            bub_q      <= bub_d;
            br_jmp_q   <= br_jmp_d;
            br_done_q  <= br_done_d;
            en_upc_q   <= en_upc_d;
            en_fetch_q <= en_fetch_d;
            en_dec_q   <= en_dec_d;
            en_exe_q   <= en_exe_d;
            en_wb_q    <= en_wb_d;
            br_taken_q <= br_taken_d;
        end
    end

`ifdef LC3_CTRL_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tout_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tout_q <= tout_d;
            err_q  <= err_d;
        end
    end
    assign bus.mem_err = err_q;
    assign unused = ^{bus.IR[11:9], bus.IR[4:3], bus.IR_Exec[8:0]};
`else
    assign bus.mem_err = 1'b0;
    assign unused = ^{bus.IR[11:9], bus.IR[4:3], bus.IR_Exec[8:0], 1'(MEM_TIMEOUT)};
`endif

    lc3_bypass_unit u_bypass (
        .ir_op (ir_op),
        .ir_sr1(bus.IR[8:6]),
        .ir_sr2(bus.IR[2:0]),
        .ir_imm(bus.IR[5]),
        .ex_op (ex_op),
        .ex_dr (bus.IR_Exec[11:9]),
        .alu_1 (alu_1),
        .alu_2 (alu_2),
        .mem_1 (mem_1),
        .mem_2 (mem_2)
    );

    assign bus.enable_updatePC  = en_upc_q;
    assign bus.enable_fetch     = en_fetch_q;
    assign bus.enable_decode    = en_dec_q;
    assign bus.enable_execute   = en_exe_q;
    assign bus.enable_writeback = en_wb_q;
    assign bus.br_taken         = br_taken_q;
    assign bus.mem_state        = mem_q;
    assign bus.bypass_alu_1     = reset & alu_1;
    assign bus.bypass_alu_2     = reset & alu_2;
    assign bus.bypass_mem_1     = reset & mem_1;
    assign bus.bypass_mem_2     = reset & mem_2;
endmodule

// File: tb/tb_lc3_pipe_controller.sv
// tb_lc3_pipe_controller: directed checks of fill, memory stalls, branch bubbles, bypass and async reset.
module tb_lc3_pipe_controller;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    lc3_pipe_controller_if bus();
    lc3_pipe_controller dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    function automatic logic [4:0] en();
        return {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode,
                bus.enable_execute, bus.enable_writeback};
    endfunction

    function automatic logic [3:0] byp();
        return {bus.bypass_alu_1, bus.bypass_alu_2, bus.bypass_mem_1, bus.bypass_mem_2};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input string tag, input logic [4:0] e, input logic [1:0] ms, input logic br);
        tick();
        chk({tag, ".en"}, 16'(en()), 16'(e));
        chk({tag, ".ms"}, 16'(bus.mem_state), 16'(ms));
        chk({tag, ".br"}, 16'(bus.br_taken), 16'(br));
    endtask

    task automatic bp(input string tag, input logic [15:0] ir, input logic [15:0] ex, input logic [3:0] exp);
        bus.IR = ir;
        bus.IR_Exec = ex;
        #1;
        chk(tag, 16'(byp()), 16'(exp));
    endtask

    initial begin
        bus.complete_instr = 1'b1;
        bus.complete_data  = 1'b0;
        bus.IR      = 16'h1042;
        bus.IR_Exec = 16'h1283;
        bus.NZP = 3'b000;
        bus.psr = 3'b000;
        #12;
        chk("rst.en", 16'(en()), 16'h0);
        chk("rst.ms", 16'(bus.mem_state), 16'h3);
        chk("rst.br", 16'(bus.br_taken), 16'h0);
        chk("rst.byp", 16'(byp()), 16'h0);
        chk("rst.err", 16'(bus.mem_err), 16'h0);
        bus.IR = 16'hF025;
        bus.IR_Exec = 16'hF025;
        reset = 1'b1;
        step("fill1", 5'b11000, 2'd3, 1'b0);
        step("fill2", 5'b11100, 2'd3, 1'b0);
        step("fill3", 5'b11110, 2'd3, 1'b0);
        step("fill4", 5'b11111, 2'd3, 1'b0);
        step("steady", 5'b11111, 2'd3, 1'b0);
        bp("byp.alu1", 16'h1042, 16'h1283, 4'b1000);
        bp("byp.mem12", 16'h1241, 16'h2205, 4'b0011);
        bp("byp.alu2", 16'h1001, 16'h1283, 4'b0100);
        bp("byp.ld_dst", 16'h2040, 16'h1283, 4'b0000);
        bp("byp.st_src", 16'h1042, 16'h3283, 4'b0000);
        bus.IR = 16'hF025;
        bus.IR_Exec = 16'hF025;
        // LD: three cycles in READ with writeback only, one idle gap, then restore
        bus.IR_Exec = 16'h2205;
        step("ld0", 5'b00001, 2'd0, 1'b0);
        step("ld1", 5'b00001, 2'd0, 1'b0);
        step("ld2", 5'b00001, 2'd0, 1'b0);
        bus.complete_data = 1'b1;
        step("ld_done", 5'b00000, 2'd3, 1'b0);
        bus.complete_data = 1'b0;
        step("ld_restore", 5'b11111, 2'd3, 1'b0);
        bus.IR_Exec = 16'hF025;
        step("ld_steady", 5'b11111, 2'd3, 1'b0);
        bus.IR_Exec = 16'hB205;
        step("sti0", 5'b00000, 2'd1, 1'b0);
        step("sti1", 5'b00000, 2'd1, 1'b0);
        bus.complete_data = 1'b1;
        step("sti2", 5'b00000, 2'd2, 1'b0);
        bus.complete_data = 1'b0;
        step("sti3", 5'b00000, 2'd2, 1'b0);
        bus.complete_data = 1'b1;
        step("sti4", 5'b00000, 2'd3, 1'b0);
        bus.complete_data = 1'b0;
        bus.IR_Exec = 16'hF025;
        step("sti5", 5'b11111, 2'd3, 1'b0);
        bus.NZP = 3'b010;
        bus.psr = 3'b010;
        bus.IR = 16'h0A03;
        step("brt0", 5'b00011, 2'd3, 1'b0);
        bus.IR = 16'hF025;
        step("brt1", 5'b00011, 2'd3, 1'b0);
        step("brt2", 5'b00011, 2'd3, 1'b1);
        step("brt3", 5'b11111, 2'd3, 1'b0);
        step("brt4", 5'b11111, 2'd3, 1'b0);
        bus.psr = 3'b100;
        bus.IR = 16'h0A03;
        step("brn0", 5'b00011, 2'd3, 1'b0);
        bus.IR = 16'hF025;
        step("brn1", 5'b00011, 2'd3, 1'b0);
        step("brn2", 5'b00011, 2'd3, 1'b0);
        step("brn3", 5'b11111, 2'd3, 1'b0);
        step("brn4", 5'b11111, 2'd3, 1'b0);
        bus.NZP = 3'b000;
        bus.psr = 3'b000;
        bus.IR = 16'hC1C0;
        step("jmp0", 5'b00011, 2'd3, 1'b0);
        bus.IR = 16'hF025;
        step("jmp1", 5'b00011, 2'd3, 1'b0);
        step("jmp2", 5'b00011, 2'd3, 1'b1);
        step("jmp3", 5'b11111, 2'd3, 1'b0);
        step("jmp4", 5'b11111, 2'd3, 1'b0);
        bus.complete_instr = 1'b0;
        step("ci0", 5'b00111, 2'd3, 1'b0);
        step("ci1", 5'b00111, 2'd3, 1'b0);
        bus.complete_instr = 1'b1;
        step("ci2", 5'b11111, 2'd3, 1'b0);
        // load and branch together: memory stall first, bubbles resume afterwards
        bus.NZP = 3'b010;
        bus.psr = 3'b010;
        bus.IR_Exec = 16'h2205;
        bus.IR = 16'h0A03;
        step("pri0", 5'b00001, 2'd0, 1'b0);
        bus.IR = 16'hF025;
        step("pri1", 5'b00001, 2'd0, 1'b0);
        bus.complete_data = 1'b1;
        step("pri2", 5'b00000, 2'd3, 1'b0);
        bus.complete_data = 1'b0;
        bus.IR_Exec = 16'hF025;
        step("pri3", 5'b00011, 2'd3, 1'b0);
        step("pri4", 5'b00011, 2'd3, 1'b1);
        step("pri5", 5'b11111, 2'd3, 1'b0);
        bus.IR_Exec = 16'h2205;
        bus.IR = 16'h1042;
        step("ar0", 5'b00001, 2'd0, 1'b0);
        #1;
        chk("ar.byp_pre", 16'(byp()), 16'h2);
        reset = 1'b0;
        #1;
        chk("ar.en", 16'(en()), 16'h0);
        chk("ar.ms", 16'(bus.mem_state), 16'h3);
        chk("ar.br", 16'(bus.br_taken), 16'h0);
        chk("ar.byp", 16'(byp()), 16'h0);
        bus.IR_Exec = 16'hF025;
        bus.IR = 16'hF025;
        #1;
        reset = 1'b1;
        step("refill1", 5'b11000, 2'd3, 1'b0);
        step("refill2", 5'b11100, 2'd3, 1'b0);
        chk("err", 16'(bus.mem_err), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lc3_pipe_controller.md
Name: lc3_pipe_controller

Overview:
- Central sequencing controller for the LC-3 pipeline.
- Drives the per-stage enables (updatePC, fetch, decode, execute, writeback) and the memory-access state for LD/ST/LDI/STI.
- Inserts branch bubbles and selects ALU/memory bypass paths.
- Consumes the instruction words held by the decode and execute stages, plus memory completion flags.

Parameters:
- BR_BUBBLES, 3, number of cycles fetch/updatePC/decode are held off after a BR/JMP enters decode.
- MEM_TIMEOUT, 255, maximum cycles a memory state waits for complete_data (used only with the optional feature).

Ports:
- clock  in  1  single system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- complete_instr  in  1  instruction memory returned valid word this cycle.
- complete_data  in  1  data memory access finished this cycle.
- IR  in  16  instruction currently in decode→execute register.
- IR_Exec  in  16  instruction currently in execute→writeback register.
- NZP  in  3  condition codes of the branch in execute.
- psr  in  3  current processor status NZP.
- enable_updatePC  out  1  PC register update enable.
- enable_fetch  out  1  fetch stage enable.
- enable_decode  out  1  decode stage enable.
- enable_execute  out  1  execute stage enable.
- enable_writeback  out  1  writeback stage enable.
- br_taken  out  1  one-cycle pulse, redirect PC.
- mem_state  out  2  0=read, 1=indirect read, 2=write, 3=idle.
- bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2  out  1 each  operand forwarding selects.
- mem_err  out  1  memory timeout flag (only with the optional feature; tied 0 otherwise).

Behaviour:
- Reset (reset=0, async):
  - All enables 0; br_taken 0; mem_state 3; bypass outputs 0; fill counter 0; bubble counter 0.
  - Reset mid-operation abandons any stall and restarts the fill sequence.
- Pipeline fill, first edges after reset release:
  - Edge 1: updatePC, fetch = 1.
  - Edge 2: + decode.
  - Edge 3: + execute.
  - Edge 4: + writeback.
  - All enables are registered outputs.
- Instruction memory wait: while complete_instr=0, updatePC and fetch are held 0. Other stages are unaffected.
- Memory FSM, entered the cycle after IR_Exec[15:12] is a memory opcode with enable_execute=1:
  - States: IDLE(3) → READ(0) for LD 0010 / LDR 0110.
  - IDLE → WRITE(2) for ST 0011 / STR 0111.
  - IDLE → IND(1) → READ for LDI 1010.
  - IDLE → IND → WRITE for STI 1011.
  - Each non-IDLE state holds until complete_data=1, then advances; the final state returns to IDLE.
  - While not IDLE: updatePC, fetch, decode, execute = 0.
  - writeback = 1 only during READ (loads); 0 during IND/WRITE.
  - On return to IDLE: stage enables restore the following cycle.
- Branch/jump:
  - When IR[15:12] is BR 0000 or JMP 1100 and enable_decode=1, load the bubble counter with BR_BUBBLES.
  - While the counter is non-zero: updatePC, fetch, decode = 0; the counter decrements each edge.
  - br_taken pulses 1 cycle when the counter hits 1:
    - JMP: br_taken = 1.
    - BR: br_taken = |(NZP & psr).
- Priority: an active memory stall freezes the bubble counter; memory and branch conditions arising in the same cycle are both honoured, memory first.
- Bypass (combinational from IR, IR_Exec):
  - bypass_alu_1 = IR_Exec op ∈ {ADD 0001, AND 0101, NOT 1001} and IR_Exec[11:9]==IR[8:6], with IR op ∈ {ADD, AND, NOT, LDR, STR, JMP}.
  - bypass_alu_2 = same ALU condition and IR[5]==0 and IR_Exec[11:9]==IR[2:0], with IR op ∈ {ADD, AND}.
  - bypass_mem_1/2 use the same register matches with IR_Exec op ∈ {LD, LDR, LDI}.
  - All bypass outputs are 0 during reset.

Optional Feature:
- LC3_CTRL_TIMEOUT_EN defined:
  - A counter runs in any non-IDLE memory state.
  - If it reaches MEM_TIMEOUT without complete_data, the FSM forces IDLE and mem_err is set sticky until reset.
- Undefined: no counter; mem_err tied 0; the FSM waits indefinitely.

Decomposition:
- Shared package lc3_ctrl_pkg holds:
  - opcode localparams;
  - mem_state enum (MEM_READ=0, MEM_IND=1, MEM_WRITE=2, MEM_IDLE=3);
  - functions is_alu_op, is_load_op, is_store_op.
- One natural sub-module: lc3_bypass_unit, which holds the combinational forwarding logic.

Test Plan:
- Reset release, complete_instr=1, no memory/branch instructions → enables rise on edges 1/2/3/4 exactly; mem_state stays 3.
- IR_Exec=0x2205 (LD R1), complete_data asserted 3 cycles later:
  - mem_state = 0 for those cycles; fetch/decode/execute = 0; writeback = 1.
  - Enables restore one cycle after return to IDLE.
- IR_Exec=0xB205 (STI) → mem_state 1 until complete_data, then 2 until complete_data, then 3; writeback stays 0.
- IR=0x0A03 (BRnp), NZP=3'b010, psr=3'b010 → fetch held 0 for 3 cycles; br_taken pulses on the 3rd.
  - Repeat with psr=3'b100 → br_taken stays 0.
- IR_Exec=0x1283 (ADD R1,R2,R3), IR=0x1042 (ADD R0,R1,R2) → bypass_alu_1=1, bypass_alu_2=0.
- reset asserted during mem_state=0 → all outputs at reset values immediately (async). With LC3_CTRL_TIMEOUT_EN and MEM_TIMEOUT=4, withholding complete_data → mem_err=1 after 4 cycles.
